// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-access stage.
//   - funct3 encodings for load/store size and sign
//   - ResultSrc encoding that marks a load
//   - FSM state type and the store byte-lane payload with its helpers
package mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_R = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  // Byte enables plus lane-replicated data for one store beat.
  typedef struct packed {
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } store_lanes_t;

  // size = funct3[1:0]: 00 byte, 01 half, otherwise full word.
  function automatic store_lanes_t store_lanes(input logic [1:0]      size,
                                               input logic [1:0]      off,
                                               input logic [XLEN-1:0] wd);
    store_lanes_t s;
    s.be    = 4'b1111;
    s.wdata = wd;
    case (size)
      2'b00: begin
        s.be    = 4'(4'b0001 << off);
        s.wdata = {4{wd[7:0]}};
      end
      2'b01: begin
        s.be    = off[1] ? 4'b1100 : 4'b0011;
        s.wdata = {2{wd[15:0]}};
      end
      default: ;
    endcase
    return s;
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic m;
    m = 1'b0;
    case (size)
      2'b01:   m = off[0];
      2'b10:   m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a read word and
// sign- or zero-extends it according to funct3. Purely combinational.
//   word   in  32  raw read word
//   off    in  2   byte offset (address bits [1:0])
//   funct3 in  3   load size/sign
//   data   out 32  extended load data (0 for undefined funct3)
module load_extend
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = word[{off, 3'b000} +: 8];
  assign w_half = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   data = {24'd0, w_byte};
      F3_H:    data = {{16{w_half[15]}}, w_half};
      F3_HU:   data = {16'd0, w_half};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the pipelined RV32I core. Issues one
// valid/ready data-memory request per load/store, waits for read data,
// extends it, and holds StallMem high until the access completes.
// Optional build macro: MISALIGN_TRAP_EN (misaligned accesses raise
// MisalignM and issue no request).
//   clk, rst                      clock, async active-high reset
//   ALUResultM/WriteDataM/funct3M  address, store data, size/sign
//   MemWriteM/ResultSrcM           store / load (ResultSrcM==01) select
//   ReadDataM                      extended load data, valid in DONE
//   StallMem                       freezes upstream stages
//   MisalignM                      misaligned access flag
//   dmem_*                         data-memory request/response bus
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic [XLEN-1:0]       WriteDataM,
  input  logic [2:0]            funct3M,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  output logic [XLEN-1:0]       ReadDataM,
  output logic                  StallMem,
  output logic                  MisalignM,
  output logic                  dmem_valid,
  input  logic                  dmem_ready,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata
);

  mem_state_t      r_state;
  mem_state_t      w_state_nxt;
  logic [XLEN-1:0] r_rdata_q;
  logic [XLEN-1:0] w_ext;
  logic            w_mem_op;
  store_lanes_t    w_lanes;
`ifdef MISALIGN_TRAP_EN
  logic            w_misalign;
  assign w_misalign = is_misaligned(funct3M[1:0], ALUResultM[1:0]);
`endif

  // A store wins when both store and load are flagged.
  assign w_mem_op = MemWriteM || (ResultSrcM == RESULT_SRC_MEM);

  // Request fields follow the frozen EX/MEM outputs directly.
  assign w_lanes    = store_lanes(funct3M[1:0], ALUResultM[1:0], WriteDataM);
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_be    = MemWriteM ? w_lanes.be : 4'b1111;
  assign dmem_wdata = w_lanes.wdata;

  load_extend u_load_extend (
    .word   (r_rdata_q),
    .off    (ALUResultM[1:0]),
    .funct3 (funct3M),
    .data   (w_ext)
  );

  // State and captured read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rdata_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == WAIT_R && dmem_rvalid) begin
        r_rdata_q <= dmem_rdata;
      end
    end
  end

  // Next state and outputs; everything forced quiet while rst is high.
  always_comb begin
    w_state_nxt = r_state;
    dmem_valid  = 1'b0;
    StallMem    = 1'b0;
    MisalignM   = 1'b0;
    ReadDataM   = '0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
`ifdef MISALIGN_TRAP_EN
            if (w_misalign) begin
              MisalignM = 1'b1;
            end else begin
              dmem_valid = 1'b1;
              StallMem   = 1'b1;
              if (dmem_ready) begin
                w_state_nxt = MemWriteM ? DONE : WAIT_R;
              end
            end
`else
            dmem_valid = 1'b1;
            StallMem   = 1'b1;
            if (dmem_ready) begin
              w_state_nxt = MemWriteM ? DONE : WAIT_R;
            end
`endif
          end
        end
        WAIT_R: begin
          StallMem = 1'b1;
          if (dmem_rvalid) begin
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          ReadDataM   = w_ext;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage block of the 5-stage pipelined RV32I core. It sits directly downstream of the EX/MEM pipeline register and consumes ALUResultM, WriteDataM, funct3M, MemWriteM and ResultSrcM.
- Drives a valid/ready data-memory bus with byte-lane alignment.
- Waits for load data, sign/zero-extends it, and raises StallMem to freeze upstream stages until the access completes.
- Produces ReadDataM for the MEM/WB register.

Parameters:
- ADDR_WIDTH, 32, width of dmem_addr (low bits of ALUResultM, word-aligned).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store data (rs2)
- funct3M  in  3  access size/sign
- MemWriteM  in  1  store
- ResultSrcM  in  2  2'b01 = load
- ReadDataM  out  32  extended load data, valid while state==DONE
- StallMem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- MisalignM  out  1  misaligned access flag (MISALIGN_TRAP_EN only; else tied 0)
- dmem_valid  out  1  request valid
- dmem_ready  in  1  request accepted
- dmem_we  out  1  write request
- dmem_addr  out  ADDR_WIDTH  {ALUResultM[ADDR_WIDTH-1:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word

Behaviour:
- Memory op: MemWriteM=1 (store) or ResultSrcM==2'b01 (load). Both set together is treated as a store.
- Reset (async, any state): state=IDLE, rdata_q=0. Outputs: dmem_valid=0, StallMem=0, ReadDataM=0, MisalignM=0.
- FSM states: IDLE, WAIT_R, DONE.
- IDLE:
  - Memory op present: dmem_valid=1 and StallMem=1.
  - On dmem_ready: store → DONE; load → WAIT_R.
  - Non-memory op: dmem_valid=0, StallMem=0, stay in IDLE.
- WAIT_R:
  - dmem_valid=0, StallMem=1.
  - On dmem_rvalid: rdata_q<=dmem_rdata, → DONE.
  - dmem_rvalid arriving in the same cycle as dmem_ready (in IDLE) is ignored.
- DONE:
  - StallMem=0, dmem_valid=0.
  - ReadDataM = extend(rdata_q).
  - Next edge → IDLE unconditionally. The instruction leaves MEM on this edge, so it is never re-issued.
- Minimum occupancy: store 2 cycles, load 3 cycles. Each wait cycle on ready or rvalid adds 1.
- Request stability: dmem_addr, dmem_be, dmem_wdata and dmem_we are derived combinationally from the held EX/MEM outputs. They are stable while dmem_valid=1 because StallMem freezes EX/MEM.
- Byte lanes, off = ALUResultM[1:0]:
  - SB: be=4'b0001<<off, wdata={4{WriteDataM[7:0]}}.
  - SH: be=off[1]?4'b1100:4'b0011, wdata={2{WriteDataM[15:0]}}.
  - SW: be=4'b1111, wdata=WriteDataM.
  - Loads: be=4'b1111, dmem_we=0.
- Load extension:
  - LB/LBU: select byte [8*off+:8], then sign-/zero-extend.
  - LH/LHU: select half by off[1], then sign-/zero-extend.
  - LW: full word.
  - Undefined funct3 (011, 110, 111): ReadDataM=0.
- Misalignment without the macro: addr[0] is ignored for halfwords; addr[1:0] is ignored for words.
- Outside DONE, ReadDataM=0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0) issues no bus request.
  - StallMem=0 and MisalignM=1 combinationally for that cycle.
  - ReadDataM=0, FSM stays IDLE.
- Undefined: MisalignM tied 0; alignment behaviour as in Behaviour.

Decomposition:
- Package mem_pkg:
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - RESULT_SRC_MEM=2'b01.
  - typedef enum logic [1:0] mem_state_t {IDLE, WAIT_R, DONE}.
- Sub-module load_extend: combinational; inputs word, off[1:0], funct3; output 32-bit extended data. It is reusable by the single-cycle core.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, dmem_ready tied 1 → cycle0: dmem_valid=1, be=1111, addr=0x100, StallMem=1; cycle1: DONE, StallMem=0; cycle2: IDLE.
- LB addr 0x203, rdata 0x80xxxxxx, rvalid 2 cycles after accept → StallMem high 3 cycles, then ReadDataM=0xFFFFFF80 for one cycle. Same with LBU → 0x00000080.
- SH addr 0x042, WriteDataM=0x1234ABCD → be=1100, wdata=0xABCDABCD. LHU addr 0x042, rdata 0xABCD0000 → 0x0000ABCD.
- dmem_ready held low 5 cycles during SB addr 0x001 → dmem_valid, be=0010 and addr=0x000 stable throughout; StallMem high 6 cycles.
- rst asserted while in WAIT_R → same cycle dmem_valid=0, StallMem=0, ReadDataM=0. After release, a back-to-back ADD passes with no stall.
- MISALIGN_TRAP_EN: LW addr 0x102 → MisalignM=1, dmem_valid=0, StallMem=0. Without the macro: request at addr 0x100, be=1111.
